// File: rtl/cpu_mode_loader.sv
// Front-panel loader for a small CPU. Debounced keys select IDLE / IN / CHECK / RUN.
// In IN mode, a step key writes the switch value to memory. In CHECK mode, a step key
// reads one word back to the display. In RUN mode the memory port is handed to the CPU.
module cpu_mode_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_in,
    input  logic              key_check,
    input  logic              key_run,
    input  logic              key_step,
    input  logic [DATA_W-1:0] sw_data,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        cpustate,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic              mem_sel,
    output logic [DATA_W-1:0] disp_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        IN_M  = 2'b01,
        CHECK = 2'b10,
        RUN   = 2'b11
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] wdata_n;
    logic              we_n, re_n;

    // Key pipeline: bit 0 = in, 1 = check, 2 = run, 3 = step
    logic [3:0] key_p0, key_p1, key_p2;
    logic [3:0] key_ev;
    logic       re_p1;

    // Two-flop synchronizer followed by a delay flop used for rising-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_p0 <= '0;
            key_p1 <= '0;
            key_p2 <= '0;
        end else begin
            key_p0 <= {key_step, key_run, key_check, key_in};
            key_p1 <= key_p0;
            key_p2 <= key_p1;
        end
    end

    assign key_ev = key_p1 & ~key_p2;

    // Mode, address and memory-strobe registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            re_p1     <= 1'b0;
            disp_data <= '0;
        end else begin
            state     <= state_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
            mem_we    <= we_n;
            mem_re    <= re_n;
            re_p1     <= mem_re;
            // Read data is valid one cycle after the memory has sampled mem_re
            if (re_p1) begin
                disp_data <= mem_rdata;
            end
        end
    end

    // Next-state logic: mode keys have priority over step, and in > check > run
    always_comb begin
        state_n = state;
        addr_n  = mem_addr;
        wdata_n = mem_wdata;
        we_n    = 1'b0;
        re_n    = 1'b0;
        // A strobe that was high this cycle ends now and advances the address
        if (mem_we || mem_re) begin
            addr_n = mem_addr + ADDR_W'(1);
        end
        if (key_ev[0]) begin
            state_n = IN_M;
            addr_n  = '0;
        end else if (key_ev[1]) begin
            state_n = CHECK;
            addr_n  = '0;
        end else if (key_ev[2]) begin
            // RUN keeps the address where it is, even over a pending increment
            state_n = RUN;
            addr_n  = mem_addr;
        end else if (key_ev[3] && !mem_we && !mem_re) begin
            if (state == IN_M) begin
                we_n    = 1'b1;
                wdata_n = sw_data;
            end else if (state == CHECK) begin
                re_n = 1'b1;
            end
        end
    end

    assign cpustate = state;
    assign mem_sel  = (state != RUN);

endmodule

// File: tb/tb_cpu_mode_loader.sv
// Directed bench for cpu_mode_loader with a one-cycle-latency memory read model.
module tb_cpu_mode_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_in, key_check, key_run, key_step;
    logic [7:0] sw_data;
    logic [7:0] mem_rdata;
    logic [1:0] cpustate;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we, mem_re, mem_sel;
    logic [7:0] disp_data;
    logic [7:0] rd_val;

    int errors = 0;
    int checks = 0;

    cpu_mode_loader #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .key_check (key_check),
        .key_run   (key_run),
        .key_step  (key_step),
        .sw_data   (sw_data),
        .mem_rdata (mem_rdata),
        .cpustate  (cpustate),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_sel   (mem_sel),
        .disp_data (disp_data)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory: data appears one edge after mem_re is sampled
    initial mem_rdata = 8'h00;
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= rd_val;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One complete step press: effect lands on the 3rd edge, strobe ends on the 4th
    task automatic step_once();
        key_step = 1'b1;
        tick(3);
        key_step = 1'b0;
        tick(3);
    endtask

    initial begin
        rst = 1'b0;
        key_in = 0; key_check = 0; key_run = 0; key_step = 0;
        sw_data = 8'h00;
        rd_val = 8'h00;
        #1;
        chk("rst_state", cpustate, 2'b00);
        chk("rst_addr", mem_addr, 8'h00);
        chk("rst_sel", mem_sel, 1'b1);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_disp", disp_data, 8'h00);
        tick(2);
        rst = 1'b1;
        tick(2);

        // Enter IN: visible on the 3rd edge, not before
        key_in = 1'b1;
        tick(2);
        chk("in_lat2", cpustate, 2'b00);
        tick(1);
        chk("in_state", cpustate, 2'b01);
        chk("in_addr", mem_addr, 8'h00);
        chk("in_sel", mem_sel, 1'b1);
        key_in = 1'b0;
        tick(3);

        // Write A5 at address 0; a held step must give one write only
        sw_data = 8'hA5;
        key_step = 1'b1;
        tick(3);
        chk("wr_we", mem_we, 1'b1);
        chk("wr_addr", mem_addr, 8'h00);
        chk("wr_data", mem_wdata, 8'hA5);
        chk("wr_re", mem_re, 1'b0);
        tick(1);
        chk("wr_we_end", mem_we, 1'b0);
        chk("wr_addr_inc", mem_addr, 8'h01);
        tick(2);
        chk("step_held", mem_we, 1'b0);
        key_step = 1'b0;
        tick(3);

        // Advance to the top address, then check wrap
        for (int i = 0; i < 254; i++) step_once();
        chk("addr_top", mem_addr, 8'hFF);
        sw_data = 8'h5A;
        key_step = 1'b1;
        tick(3);
        chk("wrap_we", mem_we, 1'b1);
        chk("wrap_addr", mem_addr, 8'hFF);
        tick(1);
        chk("wrap_zero", mem_addr, 8'h00);
        key_step = 1'b0;
        tick(3);

        // CHECK mode read-back of 3C
        key_check = 1'b1;
        tick(3);
        chk("chk_state", cpustate, 2'b10);
        chk("chk_addr", mem_addr, 8'h00);
        key_check = 1'b0;
        tick(3);
        rd_val = 8'h3C;
        key_step = 1'b1;
        tick(3);
        chk("rd_re", mem_re, 1'b1);
        chk("rd_we", mem_we, 1'b0);
        chk("rd_addr", mem_addr, 8'h00);
        tick(1);
        chk("rd_re_end", mem_re, 1'b0);
        chk("rd_addr_inc", mem_addr, 8'h01);
        chk("disp_early", disp_data, 8'h00);
        tick(1);
        chk("disp_val", disp_data, 8'h3C);
        key_step = 1'b0;
        tick(3);

        // Simultaneous in + run: in wins
        key_in = 1'b1;
        key_run = 1'b1;
        tick(3);
        chk("prio_state", cpustate, 2'b01);
        key_in = 1'b0;
        key_run = 1'b0;
        tick(3);
        key_run = 1'b1;
        tick(3);
        chk("run_state", cpustate, 2'b11);
        chk("run_sel", mem_sel, 1'b0);
        chk("run_addr", mem_addr, 8'h00);
        key_run = 1'b0;
        tick(3);
        key_step = 1'b1;
        tick(3);
        chk("run_no_we", mem_we, 1'b0);
        chk("run_no_re", mem_re, 1'b0);
        tick(1);
        chk("run_no_we2", mem_we, 1'b0);
        key_step = 1'b0;
        tick(3);

        // Reset in the middle of a write pulse acts without a clock edge
        key_in = 1'b1;
        tick(3);
        key_in = 1'b0;
        tick(3);
        sw_data = 8'h77;
        key_step = 1'b1;
        tick(3);
        chk("pre_rst_we", mem_we, 1'b1);
        rst = 1'b0;
        #2;
        chk("arst_we", mem_we, 1'b0);
        chk("arst_state", cpustate, 2'b00);
        chk("arst_wdata", mem_wdata, 8'h00);
        chk("arst_disp", disp_data, 8'h00);
        chk("arst_sel", mem_sel, 1'b1);
        key_step = 1'b0;

        // Key held across reset release gives an event afterwards
        key_check = 1'b1;
        tick(1);
        rst = 1'b1;
        tick(2);
        chk("held_lat", cpustate, 2'b00);
        tick(1);
        chk("held_state", cpustate, 2'b10);
        key_check = 1'b0;
        tick(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
